// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, width defaults and the parity helper.
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int CPB_W_DEF     = 10;
    // Widest data field the parity helper accepts; callers zero-extend.
    localparam int MAX_DATA_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Parity over the data field; zero padding does not change the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts 0..cpb-1 and pulses bit_done on the terminal count.
// Latency: bit_done is combinational from the count; first pulse cpb cycles after clear drops.
// Backpressure: none; clear holds the count at zero.
module uart_baud_timer import uart_pkg::*; #(
    parameter int CPB_W = CPB_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CPB_W-1:0] cpb,
    output logic             bit_done
);

    logic [CPB_W-1:0] cnt_q;
    logic [CPB_W-1:0] cnt_d;

    // Terminal count; suppressed while cleared so an idle owner never advances.
    assign bit_done = !clear && (cnt_q == (cpb - CPB_W'(1)));

    // Next count: wrap to zero on terminal count or clear.
    always_comb begin
        cnt_d = cnt_q + CPB_W'(1);
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB first, optional parity, stop bits; idle-high line.
// Latency: start bit appears the cycle after acceptance; frame lasts cpb*(1+DATA_BITS+PARITY_EN+STOP_BITS).
// Backpressure: tx_ready low while a frame is in flight or clk_per_bit is zero; producer holds tx_valid.
module uart_tx import uart_pkg::*; #(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int CPB_W      = CPB_W_DEF,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPB_W-1:0]     clk_per_bit,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int IDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [CPB_W-1:0]       cpb_q, cpb_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   bit_done;
    logic                   accept;
    logic [MAX_DATA_BITS-1:0] par_in;

    // A zero bit period disables the block entirely.
    assign tx_ready = (state_q == IDLE) && (clk_per_bit != '0) && !rst;
    assign accept   = tx_valid && tx_ready;
    assign tx       = tx_q;
    assign busy     = busy_q;

    // Timer is held at zero while idle so the start bit gets a full period.
    uart_baud_timer #(
        .CPB_W(CPB_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == IDLE),
        .cpb      (cpb_q),
        .bit_done (bit_done)
    );

    // Next-state, shift register and registered line value for the coming cycle.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        cpb_d     = cpb_q;
        parity_d  = parity_q;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        par_in    = '0;
        par_in[DATA_BITS-1:0] = tx_data;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    data_d    = tx_data;
                    cpb_d     = clk_per_bit;
                    bit_idx_d = '0;
                    parity_d  = calc_parity(par_in, 1'(PARITY_ODD));
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == LAST_DATA) begin
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        data_d    = data_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d   = STOP;
                    bit_idx_d = '0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (bit_idx_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line value follows the state being entered so tx is glitch-free and registered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            data_q    <= '0;
            cpb_q     <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            cpb_q     <= cpb_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule
